// File: rtl/xy_scan_timer.sv
// Raster scan timing generator: prescaled pixel advance over a full h/v frame,
// with registered sync/active decode, line/frame strobes and a frame counter.
module xy_scan_timer #(
  parameter int   H_ACTIVE  = 640,
  parameter int   H_FP      = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BP      = 48,
  parameter int   V_ACTIVE  = 480,
  parameter int   V_FP      = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BP      = 33,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0,
  parameter int   CLK_DIV   = 4,
  parameter int   FRAME_W   = 8
) (
  input  logic                                                clock,
  input  logic                                                reset_n,
  input  logic                                                enable,
  output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0]        x,
  output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0]        y,
  output logic                                                pixel_tick,
  output logic                                                active,
  output logic                                                hsync,
  output logic                                                vsync,
  output logic                                                line_start,
  output logic                                                frame_start,
  output logic [FRAME_W-1:0]                                  frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int X_W     = $clog2(H_TOTAL);
  localparam int Y_W     = $clog2(V_TOTAL);
  localparam int PS_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [X_W-1:0]  X_LAST   = X_W'(H_TOTAL - 1);
  localparam logic [Y_W-1:0]  Y_LAST   = Y_W'(V_TOTAL - 1);
  localparam logic [X_W-1:0]  X_ACT    = X_W'(H_ACTIVE);
  localparam logic [Y_W-1:0]  Y_ACT    = Y_W'(V_ACTIVE);
  localparam logic [X_W-1:0]  HS_START = X_W'(H_ACTIVE + H_FP);
  localparam logic [X_W-1:0]  HS_END   = X_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [Y_W-1:0]  VS_START = Y_W'(V_ACTIVE + V_FP);
  localparam logic [Y_W-1:0]  VS_END   = Y_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [PS_W-1:0] PS_LAST  = PS_W'(CLK_DIV - 1);

  logic [PS_W-1:0]    ps_q, ps_d;
  logic [X_W-1:0]     x_q, x_d;
  logic [Y_W-1:0]     y_q, y_d;
  logic [FRAME_W-1:0] frame_count_q, frame_count_d;
  logic               pixel_tick_q, pixel_tick_d;
  logic               line_start_q, line_start_d;
  logic               frame_start_q, frame_start_d;
  logic               active_q, active_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               advance;

  always_comb begin
    ps_d          = ps_q;
    x_d           = x_q;
    y_d           = y_q;
    frame_count_d = frame_count_q;
    pixel_tick_d  = 1'b0;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    advance       = enable && (ps_q == PS_LAST);

    if (enable) begin
      ps_d = advance ? '0 : ps_q + PS_W'(1);
    end

    if (advance) begin
      pixel_tick_d = 1'b1;
      if (x_q == X_LAST) begin
        x_d          = '0;
        line_start_d = 1'b1;
        if (y_q == Y_LAST) begin
          y_d           = '0;
          frame_start_d = 1'b1;
          frame_count_d = frame_count_q + FRAME_W'(1);
        end else begin
          y_d = y_q + Y_W'(1);
        end
      end else begin
        x_d = x_q + X_W'(1);
      end
    end

    // Decode from the next coordinates so levels line up with the visible x/y.
    active_d = (x_d < X_ACT) && (y_d < Y_ACT);
    hsync_d  = ((x_d >= HS_START) && (x_d < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
    vsync_d  = ((y_d >= VS_START) && (y_d < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ps_q          <= '0;
      x_q           <= '0;
      y_q           <= '0;
      frame_count_q <= '0;
      pixel_tick_q  <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      active_q      <= 1'b1;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
    end else begin
      ps_q          <= ps_d;
      x_q           <= x_d;
      y_q           <= y_d;
      frame_count_q <= frame_count_d;
      pixel_tick_q  <= pixel_tick_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      active_q      <= active_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign frame_count = frame_count_q;
  assign pixel_tick  = pixel_tick_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign active      = active_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;

endmodule

// File: tb/tb_xy_scan_timer.sv
// Bench for xy_scan_timer: small 8x6 config with random enable against an
// arithmetic pixel-count model, a FRAME_W=2 instance and the default 800x525 timing.
module tb_xy_scan_timer;

  localparam int CD = 2;
  localparam int HT = 8;
  localparam int VT = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Instance A: small config, FRAME_W=8
  logic       rst_a, en_a;
  logic [2:0] x_a, y_a;
  logic       tick_a, act_a, hs_a, vs_a, ls_a, fs_a;
  logic [7:0] fc_a;

  xy_scan_timer #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CLK_DIV(CD), .FRAME_W(8)
  ) dut_a (
    .clock(clk), .reset_n(rst_a), .enable(en_a), .x(x_a), .y(y_a),
    .pixel_tick(tick_a), .active(act_a), .hsync(hs_a), .vsync(vs_a),
    .line_start(ls_a), .frame_start(fs_a), .frame_count(fc_a)
  );

  // Instance B: small config, FRAME_W=2
  logic       rst_b, en_b;
  logic [2:0] x_b, y_b;
  logic       tick_b, act_b, hs_b, vs_b, ls_b, fs_b;
  logic [1:0] fc_b;

  xy_scan_timer #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CLK_DIV(CD), .FRAME_W(2)
  ) dut_b (
    .clock(clk), .reset_n(rst_b), .enable(en_b), .x(x_b), .y(y_b),
    .pixel_tick(tick_b), .active(act_b), .hsync(hs_b), .vsync(vs_b),
    .line_start(ls_b), .frame_start(fs_b), .frame_count(fc_b)
  );

  // Instance C: default 640x480 timing, CLK_DIV=1
  logic       rst_c, en_c;
  logic [9:0] x_c, y_c;
  logic       tick_c, act_c, hs_c, vs_c, ls_c, fs_c;
  logic [7:0] fc_c;

  xy_scan_timer #(.CLK_DIV(1)) dut_c (
    .clock(clk), .reset_n(rst_c), .enable(en_c), .x(x_c), .y(y_c),
    .pixel_tick(tick_c), .active(act_c), .hsync(hs_c), .vsync(vs_c),
    .line_start(ls_c), .frame_start(fs_c), .frame_count(fc_c)
  );

  // Reference model for A: enabled clocks since reset, plus whether the last clock advanced.
  longint na;
  logic   m_tick;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_a();
    longint p;
    int ex, ey, ef;
    p  = na / CD;
    ex = int'(p % HT);
    ey = int'((p / HT) % VT);
    ef = int'((p / (HT * VT)) % 256);
    chk("a_x", 32'(x_a), 32'(ex));
    chk("a_y", 32'(y_a), 32'(ey));
    chk("a_fc", 32'(fc_a), 32'(ef));
    chk("a_tick", 32'(tick_a), 32'(m_tick));
    chk("a_line_start", 32'(ls_a), 32'(m_tick && ex == 0));
    chk("a_frame_start", 32'(fs_a), 32'(m_tick && ex == 0 && ey == 0));
    chk("a_active", 32'(act_a), 32'(ex < 4 && ey < 3));
    chk("a_hsync", 32'(hs_a), 32'(!(ex >= 5 && ex < 7)));
    chk("a_vsync", 32'(vs_a), 32'(ey != 4));
  endtask

  // Called at a negedge with en_a already driven; returns at the next negedge after checking.
  task automatic step_a();
    @(posedge clk);
    if (rst_a && en_a) begin
      na++;
      m_tick = (na % CD == 0);
    end else begin
      m_tick = 1'b0;
    end
    @(negedge clk);
    check_a();
  endtask

  initial begin
    int act_cnt, hs_cnt, vs_cnt, fs_clk, fs_seen;
    int fc_exp [5];
    int fc_got [$];
    int ls_clk [$];
    int hs_low_c;

    rst_a = 1'b0; en_a = 1'b0;
    rst_b = 1'b0; en_b = 1'b0;
    rst_c = 1'b0; en_c = 1'b0;
    na = 0; m_tick = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check_a();

    // Enable held high from reset release; first frame_start at clock 96
    rst_a = 1'b1; en_a = 1'b1;
    fs_clk = -1;
    for (int c = 1; c <= 100; c++) begin
      step_a();
      if (c == 16) chk("a_y_after16", 32'(y_a), 32'd1);
      if (fs_a && fs_clk < 0) fs_clk = c;
    end
    chk("a_first_frame_start_clk", 32'(fs_clk), 32'd96);

    // One full frame sweep counted at pixel ticks
    act_cnt = 0; hs_cnt = 0; vs_cnt = 0;
    for (int c = 0; c < HT * VT * CD; c++) begin
      step_a();
      if (tick_a) begin
        if (act_a) act_cnt++;
        if (!hs_a) hs_cnt++;
        if (!vs_a) vs_cnt++;
      end
    end
    chk("a_active_pixels", 32'(act_cnt), 32'd12);
    chk("a_hsync_low_pixels", 32'(hs_cnt), 32'd12);
    chk("a_vsync_low_pixels", 32'(vs_cnt), 32'd8);

    // Pause at x=3 with prescaler=1
    for (int i = 0; i < 200 && !((na / CD) % HT == 3 && na % CD == 1); i++) step_a();
    chk("a_pause_x", 32'(x_a), 32'd3);
    en_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step_a();
      chk("a_hold_x", 32'(x_a), 32'd3);
      chk("a_hold_tick", 32'(tick_a), 32'd0);
    end
    en_a = 1'b1;
    step_a();
    chk("a_resume_x", 32'(x_a), 32'd4);

    // Random enable
    for (int i = 0; i < 400; i++) begin
      en_a = ($urandom_range(0, 3) != 0);
      step_a();
    end

    // Asynchronous reset mid-frame at x=6,y=4
    en_a = 1'b1;
    for (int i = 0; i < 300 && !(x_a == 3'd6 && y_a == 3'd4); i++) step_a();
    chk("a_reach_x6", 32'(x_a), 32'd6);
    chk("a_reach_y4", 32'(y_a), 32'd4);
    #3 rst_a = 1'b0;
    #1;
    chk("a_arst_x", 32'(x_a), 32'd0);
    chk("a_arst_y", 32'(y_a), 32'd0);
    chk("a_arst_hsync", 32'(hs_a), 32'd1);
    chk("a_arst_vsync", 32'(vs_a), 32'd1);
    chk("a_arst_active", 32'(act_a), 32'd1);
    chk("a_arst_fc", 32'(fc_a), 32'd0);
    na = 0; m_tick = 1'b0;
    @(negedge clk);
    step_a();
    rst_a = 1'b1;
    for (int i = 0; i < 40; i++) step_a();

    // FRAME_W=2: five frames
    fc_exp = '{1, 2, 3, 0, 1};
    rst_b = 1'b1; en_b = 1'b1;
    for (int c = 1; c <= 5 * HT * VT * CD + 2; c++) begin
      @(negedge clk);
      if (fs_b) fc_got.push_back(int'(fc_b));
    end
    chk("b_frame_starts", 32'(fc_got.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < fc_got.size()) chk("b_frame_count_seq", 32'(fc_got[i]), 32'(fc_exp[i]));
      else chk("b_frame_count_seq", 32'hFFFF_FFFF, 32'(fc_exp[i]));
    end
    en_b = 1'b0;

    // Default timing, CLK_DIV=1: two lines
    rst_c = 1'b1; en_c = 1'b1;
    hs_low_c = 0;
    for (int k = 1; k <= 1700; k++) begin
      @(negedge clk);
      chk("c_x", 32'(x_c), 32'(k % 800));
      chk("c_y", 32'(y_c), 32'(k / 800));
      chk("c_tick", 32'(tick_c), 32'd1);
      chk("c_hsync", 32'(hs_c), 32'(!((k % 800) >= 656 && (k % 800) < 752)));
      chk("c_active", 32'(act_c), 32'((k % 800) < 640));
      chk("c_vsync", 32'(vs_c), 32'd1);
      if (ls_c) ls_clk.push_back(k);
      if (k <= 800 && !hs_c) hs_low_c++;
    end
    chk("c_hsync_low_clocks", 32'(hs_low_c), 32'd96);
    chk("c_line_starts", 32'(ls_clk.size()), 32'd2);
    if (ls_clk.size() >= 2) begin
      chk("c_line_start_0", 32'(ls_clk[0]), 32'd800);
      chk("c_line_period", 32'(ls_clk[1] - ls_clk[0]), 32'd800);
    end

    fs_seen = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/xy_scan_timer.md
Name: xy_scan_timer

Overview:
- Parametrised raster scan generator and successor to the simple x/y counter.
- Produces pixel x/y coordinates over a full horizontal/vertical timing frame (active, front porch, sync, back porch).
- Also produces sync, active-video, line/frame strobes and a frame counter.
- Sits between the system clock and the display/pixel-fetch logic; one pixel advances every CLK_DIV enabled clocks.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch pixels
- H_SYNC, 96, horizontal sync pixels
- H_BP, 48, horizontal back porch pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch lines
- V_SYNC, 2, vertical sync lines
- V_BP, 33, vertical back porch lines
- HSYNC_POL, 0, asserted level of hsync
- VSYNC_POL, 0, asserted level of vsync
- CLK_DIV, 4, clock cycles per pixel (>=1)
- FRAME_W, 8, frame counter width

Ports:
- clock  input  1  system clock, all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- enable  input  1  advance permission; low freezes all state
- x  output  $clog2(H_TOTAL)  pixel column, H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP
- y  output  $clog2(V_TOTAL)  line number, V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP
- pixel_tick  output  1  one-cycle strobe on each clock where x/y advance
- active  output  1  high when x<H_ACTIVE and y<V_ACTIVE
- hsync  output  1  HSYNC_POL when H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC, else ~HSYNC_POL
- vsync  output  1  VSYNC_POL when V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC, else ~VSYNC_POL
- line_start  output  1  one-cycle strobe when x wraps to 0
- frame_start  output  1  one-cycle strobe when x and y both wrap to 0
- frame_count  output  FRAME_W  completed-frame count, wraps modulo 2^FRAME_W

Behaviour:
- Reset (asynchronous, reset_n low), applies immediately, including mid-frame:
  - x=0, y=0, internal prescaler=0
  - pixel_tick=0, line_start=0, frame_start=0, frame_count=0
  - active=1, hsync=~HSYNC_POL, vsync=~VSYNC_POL
- Prescaler:
  - Counts 0..CLK_DIV-1 on each clock with enable=1.
  - Advance condition: enable=1 and prescaler==CLK_DIV-1; prescaler returns to 0 on that clock.
  - CLK_DIV=1: every enabled clock advances.
- Advance:
  - x <= (x==H_TOTAL-1) ? 0 : x+1.
  - On x wrap: y <= (y==V_TOTAL-1) ? 0 : y+1.
- Registered outputs:
  - active, hsync and vsync are decoded from the next x/y, so they are registered and change in the same cycle as x/y. No extra latency relative to the coordinates.
  - pixel_tick, line_start and frame_start are registered and high for exactly the one cycle in which the new x/y values are first visible. line_start coincides with x becoming 0. frame_start coincides with x=0,y=0 and implies line_start.
  - frame_count increments in the same cycle frame_start asserts; wraps 2^FRAME_W-1 -> 0.
- enable=0:
  - Prescaler, x, y, frame_count and decoded levels hold.
  - All strobes are 0 on the following cycle.
  - Re-enabling resumes from the held prescaler value; partial pixel periods are not lost or restarted.
- Reset release: first advance occurs CLK_DIV enabled clocks later. The (0,0) period following reset does not generate frame_start.
- Arithmetic:
  - Comparisons use unsigned widths of x/y.
  - Constants are derived at elaboration.
  - Each timing parameter must be >=1; illegal parameters are not checked in RTL (assertion in bench only).
- Sync decode windows are half-open as given in Ports.

Test Plan (small config unless noted: H 4/1/2/1 so H_TOTAL=8; V 3/1/1/1 so V_TOTAL=6; CLK_DIV=2; POL=0):
- Reset then enable held high:
  - pixel_tick every 2 clocks.
  - x runs 0..7 and wraps; line_start asserts with x=0.
  - y=1 after 16 clocks.
  - First frame_start at clock 96, frame_count=1.
- Sweep one frame:
  - hsync=0 only for x in {5,6}; vsync=0 only for y=4.
  - active=1 only for x<4 and y<3, i.e. 12 pixels per frame.
- Toggle enable low for 5 cycles mid-line at x=3 with prescaler=1:
  - x, y and frame_count hold; no strobes.
  - x=4 on the first enabled clock after re-enable.
- Assert reset_n low asynchronously between clock edges at x=6,y=4:
  - Outputs immediately show x=0, y=0, hsync=1, vsync=1, active=1, frame_count=0.
- FRAME_W=2, run 5 frames: frame_count sequence 1,2,3,0,1.
- Default 640x480 config, CLK_DIV=1:
  - Line period 800 clocks; frame period 420000 clocks.
  - hsync low for x 656..751; vsync low for y 490..491.
